// File: rtl/vga_pkg.sv
// Shared types and default constants for the dual-view VGA controller.
// Holds the view FSM encoding, default 640x480@60 timing and overlay colour.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHOW    = 2'd1,
      COMPARE = 2'd2
   } view_state_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_IMG_W    = 256;
   localparam int DEF_IMG_H    = 256;
   localparam int DEF_LEFT_X0  = 32;
   localparam int DEF_RIGHT_X0 = 352;
   localparam int DEF_IMG_Y0   = 112;
   localparam int DEF_GRID_N   = 4;
   localparam int DEF_PIX_W    = 24;
   localparam int DEF_DEB_CYC  = 250000;

   localparam logic [23:0] OVERLAY_RGB = 24'hFF0000;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: one pulse once the input has been high for DEB_CYCLES.
// The raw input is brought into the clock domain by two flops first.
module btn_debounce #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clock_25,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          btn_m;
   logic          btn_s;
   logic [CW-1:0] count;

   always_ff @(posedge clock_25) begin
      if (reset) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         count <= '0;
         pulse <= 1'b0;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
         pulse <= 1'b0;
         if (!btn_s) begin
            count <= '0;
         end else if (count != CW'(DEB_CYCLES)) begin
            // saturating at DEB_CYCLES keeps a held button to a single pulse
            count <= count + 1'b1;
            if (count == CW'(DEB_CYCLES - 1))
               pulse <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_dual_view_ctrl.sv
// Dual-view VGA controller: original image left, processed image right.
// Define CURSOR_OVERLAY_EN to draw a red border on the selected tile.
module vga_dual_view_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int LEFT_X0    = DEF_LEFT_X0,
   parameter int RIGHT_X0   = DEF_RIGHT_X0,
   parameter int IMG_Y0     = DEF_IMG_Y0,
   parameter int GRID_N     = DEF_GRID_N,
   parameter int PIX_W      = DEF_PIX_W,
   parameter int DEB_CYCLES = DEF_DEB_CYC
) (
   input  logic                                clock_25,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                proc_done,
   input  logic                                boton_cursor,
   input  logic [PIX_W-1:0]                    data_rom,
   input  logic [PIX_W-1:0]                    data_proc,
   output logic [$clog2(IMG_W*IMG_H)-1:0]      address,
   output logic [7:0]                          red,
   output logic [7:0]                          green,
   output logic [7:0]                          blue,
   output logic                                hsync,
   output logic                                vsync,
   output logic                                n_blank,
   output logic [$clog2(GRID_N*GRID_N)-1:0]    pos_cursor
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(IMG_W * IMG_H);
   localparam int CW      = $clog2(GRID_N * GRID_N);
   localparam int XW      = $clog2(IMG_W);
   localparam int YW      = $clog2(IMG_H);
   localparam int TILE_W  = IMG_W / GRID_N;
   localparam int TILE_H  = IMG_H / GRID_N;

   if ((IMG_W % GRID_N) != 0 || (IMG_H % GRID_N) != 0) begin : g_bad_grid
      $error("IMG_W and IMG_H must be multiples of GRID_N");
   end
   if (PIX_W < 24) begin : g_bad_pix
      $error("PIX_W must hold 24-bit RGB");
   end

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_last;
   logic          v_last;
   logic          frame_last;

   assign h_last     = (h == HW'(H_TOTAL - 1));
   assign v_last     = (v == VW'(V_TOTAL - 1));
   assign frame_last = h_last && v_last;

   always_ff @(posedge clock_25) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else begin
         h <= h_last ? '0 : h + 1'b1;
         if (h_last)
            v <= v_last ? '0 : v + 1'b1;
      end
   end

   view_state_t state, state_next;
   logic        start_pend, start_pend_next;
   logic        done_pend, done_pend_next;
   logic        go_start;
   logic        go_done;

   always_ff @(posedge clock_25) begin
      if (reset) begin
         state      <= IDLE;
         start_pend <= 1'b0;
         done_pend  <= 1'b0;
      end else begin
         state      <= state_next;
         start_pend <= start_pend_next;
         done_pend  <= done_pend_next;
      end
   end

   // requests are held until the frame wraps so a frame never mixes views
   always_comb begin
      go_start        = start_pend | start;
      go_done         = done_pend | proc_done;
      state_next      = state;
      start_pend_next = go_start;
      done_pend_next  = go_done;
      if (frame_last) begin
         start_pend_next = 1'b0;
         done_pend_next  = 1'b0;
         unique case (state)
            IDLE:    if (go_start) state_next = SHOW;
            SHOW:    if (go_done)  state_next = COMPARE;
            COMPARE: if (go_start) state_next = SHOW;
            default: state_next = IDLE;
         endcase
      end
   end

   logic          in_y;
   logic          in_left;
   logic          in_right;
   logic          active;
   logic          hs_n;
   logic          vs_n;
   logic [HW-1:0] lx_full;
   logic [HW-1:0] rx_full;
   logic [VW-1:0] y_full;
   logic [XW-1:0] col_x;
   logic [YW-1:0] row_y;

   assign in_y     = (v >= VW'(IMG_Y0)) && (v < VW'(IMG_Y0 + IMG_H));
   assign in_left  = in_y && (h >= HW'(LEFT_X0)) && (h < HW'(LEFT_X0 + IMG_W));
   assign in_right = in_y && (h >= HW'(RIGHT_X0)) && (h < HW'(RIGHT_X0 + IMG_W));
   assign active   = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
   assign hs_n     = !((h >= HW'(H_ACTIVE + H_FP)) &&
                       (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs_n     = !((v >= VW'(V_ACTIVE + V_FP)) &&
                       (v < VW'(V_ACTIVE + V_FP + V_SYNC)));

   assign lx_full = h - HW'(LEFT_X0);
   assign rx_full = h - HW'(RIGHT_X0);
   assign y_full  = v - VW'(IMG_Y0);
   assign col_x   = in_left ? lx_full[XW-1:0] : rx_full[XW-1:0];
   assign row_y   = y_full[YW-1:0];

   // both memories see one address so the two views stay pixel-aligned
   assign address = (in_left || in_right) ?
                    AW'(row_y) * AW'(IMG_W) + AW'(col_x) : '0;

   logic show_left;
   logic show_right;
   logic ovl_hit;

   assign show_left  = in_left && (state != IDLE);
   assign show_right = in_right && (state == COMPARE);

`ifdef CURSOR_OVERLAY_EN
   int   tcol;
   int   trow;
   int   tx;
   int   ty;
   logic on_edge;

   always_comb begin
      tcol    = int'(col_x) / TILE_W;
      trow    = int'(row_y) / TILE_H;
      tx      = int'(col_x) % TILE_W;
      ty      = int'(row_y) % TILE_H;
      on_edge = (tx < 2) || (tx >= TILE_W - 2) ||
                (ty < 2) || (ty >= TILE_H - 2);
      ovl_hit = on_edge && (show_left || show_right) &&
                (CW'(trow * GRID_N + tcol) == pos_cursor);
   end
`else
   assign ovl_hit = 1'b0;
`endif

   logic s1_left;
   logic s1_right;
   logic s1_act;
   logic s1_hs;
   logic s1_vs;
   logic s1_ovl;

   // first stage lines up with the memory read latency
   always_ff @(posedge clock_25) begin
      if (reset) begin
         s1_left  <= 1'b0;
         s1_right <= 1'b0;
         s1_act   <= 1'b0;
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
         s1_ovl   <= 1'b0;
      end else begin
         s1_left  <= show_left;
         s1_right <= show_right;
         s1_act   <= active;
         s1_hs    <= hs_n;
         s1_vs    <= vs_n;
         s1_ovl   <= ovl_hit;
      end
   end

   logic [23:0] pix;

   always_comb begin
      pix = '0;
      if (s1_act) begin
         if (s1_ovl)
            pix = OVERLAY_RGB;
         else if (s1_left)
            pix = data_rom[23:0];
         else if (s1_right)
            pix = data_proc[23:0];
      end
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         red     <= '0;
         green   <= '0;
         blue    <= '0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         n_blank <= 1'b0;
      end else begin
         red     <= pix[23:16];
         green   <= pix[15:8];
         blue    <= pix[7:0];
         hsync   <= s1_hs;
         vsync   <= s1_vs;
         n_blank <= s1_act;
      end
   end

   logic deb_pulse;

   btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb (
      .clock_25(clock_25),
      .reset   (reset),
      .btn     (boton_cursor),
      .pulse   (deb_pulse)
   );

   always_ff @(posedge clock_25) begin
      if (reset)
         pos_cursor <= '0;
      else if (deb_pulse)
         pos_cursor <= (pos_cursor == CW'(GRID_N * GRID_N - 1)) ?
                       '0 : pos_cursor + 1'b1;
   end

endmodule
